// File: rtl/regfile_writeback_buffer.sv
// Writeback FIFO in front of the register file write port with read bypass; enqueue-to-write-port is 2 edges.
// Backpressure: in_ready drops only when full; drain_stall holds the head, and bypass always reflects newest pending data.
module regfile_writeback_buffer #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_reg,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    drain_stall,
    output logic                    rf_write_enable,
    output logic [ADDR_WIDTH-1:0]   rf_write_reg,
    output logic [DATA_WIDTH-1:0]   rf_write_data,
    input  logic [ADDR_WIDTH-1:0]   read_reg1,
    input  logic [ADDR_WIDTH-1:0]   read_reg2,
    input  logic [DATA_WIDTH-1:0]   rf_read_data1,
    input  logic [DATA_WIDTH-1:0]   rf_read_data2,
    output logic [DATA_WIDTH-1:0]   read_data1,
    output logic [DATA_WIDTH-1:0]   read_data2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] reg_idx;
        logic [DATA_WIDTH-1:0] dat;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    assign in_ready = count < CNT_W'(DEPTH);
    assign empty    = count == '0;
    // Writes to r0 are accepted but never stored: r0 is hardwired to zero.
    assign push     = in_valid && in_ready && (in_reg != '0);
    assign pop      = (count != '0) && !drain_stall;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            rf_write_enable <= 1'b0;
            rf_write_reg    <= '0;
            rf_write_data   <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            count           <= count + CNT_W'(push) - CNT_W'(pop);
            rf_write_enable <= pop;
            if (pop) begin
                rf_write_reg  <= mem[head].reg_idx;
                rf_write_data <= mem[head].dat;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[tail] <= '{reg_idx: in_reg, dat: in_data};
    end

    // Walk oldest to newest so the newest matching entry wins; output stage sits below all queued entries.
    function automatic logic [DATA_WIDTH-1:0] bypass(input logic [ADDR_WIDTH-1:0] rr,
                                                     input logic [DATA_WIDTH-1:0] raw);
        logic [DATA_WIDTH-1:0] val;
        logic [PTR_W-1:0]      idx;
        val = raw;
        if (rf_write_enable && rf_write_reg == rr) val = rf_write_data;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < count && mem[idx].reg_idx == rr) val = mem[idx].dat;
        end
        if (rr == '0) val = '0;
        return val;
    endfunction

    always_comb read_data1 = bypass(read_reg1, rf_read_data1);
    always_comb read_data2 = bypass(read_reg2, rf_read_data2);

endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Scoreboarded bench for regfile_writeback_buffer against a queue-based reference model.
module tb_regfile_writeback_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 5;
    localparam int DW    = 32;

    logic          clock = 1'b0;
    logic          reset_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_reg = '0;
    logic [DW-1:0] in_data = '0;
    logic          drain_stall = 1'b0;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_reg;
    logic [DW-1:0] rf_write_data;
    logic [AW-1:0] read_reg1 = '0;
    logic [AW-1:0] read_reg2 = '0;
    logic [DW-1:0] rf_read_data1 = '0;
    logic [DW-1:0] rf_read_data2 = '0;
    logic [DW-1:0] read_data1;
    logic [DW-1:0] read_data2;
    logic [2:0]    count;
    logic          empty;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          pend[$];
    ent_t          expq[$];
    logic          m_we = 1'b0;
    logic [AW-1:0] m_reg = '0;
    logic [DW-1:0] m_data = '0;

    regfile_writeback_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
        .drain_stall(drain_stall),
        .rf_write_enable(rf_write_enable), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .read_reg1(read_reg1), .read_reg2(read_reg2),
        .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
        .read_data1(read_data1), .read_data2(read_data2),
        .count(count), .empty(empty)
    );

    initial forever #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending list plus a single output register; r0 writes vanish.
    initial forever begin : model
        bit   acc;
        ent_t e;
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            pend.delete();
            expq.delete();
            m_we   = 1'b0;
            m_reg  = '0;
            m_data = '0;
        end else begin
            acc = in_valid && (pend.size() < DEPTH);
            if (pend.size() > 0 && !drain_stall) begin
                e      = pend.pop_front();
                m_we   = 1'b1;
                m_reg  = e.r;
                m_data = e.d;
            end else begin
                m_we = 1'b0;
            end
            if (acc && in_reg != '0) begin
                e.r = in_reg;
                e.d = in_data;
                pend.push_back(e);
                expq.push_back(e);
            end
        end
    end

    function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] rr, input logic [DW-1:0] raw);
        if (rr == '0) return '0;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].r == rr) return pend[i].d;
        if (m_we && m_reg == rr) return m_data;
        return raw;
    endfunction

    initial forever begin : monitor
        ent_t e;
        @(negedge clock);
        if (reset_n) begin
            check("wr_en", rf_write_enable, m_we);
            check("wr_reg", rf_write_reg, m_reg);
            check("wr_data", rf_write_data, m_data);
            check("count", count, pend.size());
            check("empty", empty, pend.size() == 0);
            check("in_ready", in_ready, pend.size() < DEPTH);
            check("read_data1", read_data1, ref_read(read_reg1, rf_read_data1));
            check("read_data2", read_data2, ref_read(read_reg2, rf_read_data2));
            if (rf_write_enable) begin
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_write: reg %0d data %0h with no pending entry", rf_write_reg, rf_write_data);
                end else begin
                    e = expq.pop_front();
                    check("sb_reg", rf_write_reg, e.r);
                    check("sb_data", rf_write_data, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input bit v, input logic [AW-1:0] r, input logic [DW-1:0] d, input bit st);
        in_valid    = v;
        in_reg      = r;
        in_data     = d;
        drain_stall = st;
        @(posedge clock);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_we", rf_write_enable, 0);
        check("rst_reg", rf_write_reg, 0);
        check("rst_data", rf_write_data, 0);
        @(posedge clock);
        @(posedge clock);
        #2 reset_n = 1'b1;

        // single write: accepted at N, pulse after N+1
        step(1'b1, 5'd1, 32'hAABBCCDD, 1'b0);
        check("single_count", count, 1);
        step(1'b0, '0, '0, 1'b0);
        check("single_we", rf_write_enable, 1);
        check("single_reg", rf_write_reg, 1);
        check("single_data", rf_write_data, 32'hAABBCCDD);
        step(1'b0, '0, '0, 1'b0);
        check("single_we_off", rf_write_enable, 0);
        check("single_count0", count, 0);

        // r0 write is swallowed
        read_reg1 = '0;
        rf_read_data1 = 32'h55555555;
        step(1'b1, 5'd0, 32'hDEADBEEF, 1'b0);
        check("r0_count", count, 0);
        check("r0_ready", in_ready, 1);
        check("r0_read", read_data1, 0);
        idle(3);

        // fill under stall, fifth refused, then burst drain
        for (int i = 2; i <= 5; i++) step(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 1'b1);
        step(1'b1, 5'd6, 32'h66666666, 1'b1);
        check("full_count", count, 4);
        check("full_ready", in_ready, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, '0, '0, 1'b0);
            check("burst_we", rf_write_enable, i < 4);
        end

        // newest pending value wins the bypass
        read_reg1 = 5'd1;
        rf_read_data1 = '0;
        step(1'b1, 5'd1, 32'h11111111, 1'b1);
        step(1'b1, 5'd1, 32'hFACEBEEF, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        check("bypass_newest", read_data1, 32'hFACEBEEF);
        idle(4);
        rf_read_data1 = 32'h12345678;
        #1;
        check("bypass_raw", read_data1, 32'h12345678);

        // full with pop and enqueue on one edge, then sustained traffic across wraps
        for (int i = 0; i < DEPTH; i++) step(1'b1, 5'(8 + i), $urandom, 1'b1);
        step(1'b1, 5'd20, 32'hBAD0BAD0, 1'b0);
        check("full_pop_count", count, DEPTH - 1);
        for (int i = 0; i < 3 * DEPTH; i++) begin
            read_reg2 = 5'(8 + (i % 6));
            step(1'b1, 5'(8 + (i % 6)), $urandom, 1'b0);
            check("steady_count", count, DEPTH - 1);
        end
        idle(6);

        // asynchronous reset mid-drain
        for (int i = 0; i < 3; i++) step(1'b1, 5'(21 + i), $urandom, 1'b1);
        step(1'b0, '0, '0, 1'b0);
        check("pre_rst_we", rf_write_enable, 1);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_we", rf_write_enable, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        check("mid_rst_reg", rf_write_reg, 0);
        check("mid_rst_data", rf_write_data, 0);
        @(posedge clock);
        @(posedge clock);
        #4 reset_n = 1'b1;
        @(posedge clock);
        #2;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, '0, 1'b0);
            check("post_rst_we", rf_write_enable, 0);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            read_reg1     = 5'($urandom_range(0, 7));
            read_reg2     = 5'($urandom_range(0, 7));
            rf_read_data1 = $urandom;
            rf_read_data2 = $urandom;
            step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 9) < 3);
        end
        idle(10);
        check("drained_sb", expq.size(), 0);
        check("drained_count", count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
